mem_stage_sb: RTL and testbench

Parametrised memory stage with a posted-store buffer, placed between EX and WB in the pipelined core. Stores are retired to WB as soon as they enter an in-order store buffer and are drained to memory in the background. Loads take the memory port when no older store to the same word is pending. Adds byte-lane steering for any aligned offset, unsigned loads (LBU/LHU), misalignment detection and a drained indication for FENCE.

---
 rtl/mem_stage_sb_pkg.sv | 50 +++++
 rtl/mem_stage_sb_if.sv | 39 +++
 rtl/mem_stage_sb_store_buffer.sv | 65 ++++++
 rtl/mem_stage_sb.sv | 195 +++++++++++++++++++
 tb/tb_mem_stage_sb.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_sb_pkg.sv
// Shared types and helpers for the memory stage: buffer entry layout, FSM
// states, opcode/funct3 constants and byte-lane steering functions.
package mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } sb_entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DRAIN} mem_state_t;

  // Byte enables for a store of the given size, moved to the addressed lane.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_BU:   return {24'd0, sh[7:0]};
      F3_HU:   return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_sb_if.sv
// Bus bundle of the memory stage: EX handshake, memory port and WB register.
interface mem_stage_sb_if #(
  parameter int unsigned BITSIZE = 32
);
  logic               halt_i;
  logic               valid_i;
  logic               ack_o;
  logic [BITSIZE-1:0] instr_i;
  logic [BITSIZE-1:0] result_i;
  logic [BITSIZE-1:0] rs2_i;
  logic [BITSIZE-1:0] pc_i;
  logic               mem_req_o;
  logic               mem_we_o;
  logic [3:0]         mem_be_o;
  logic [BITSIZE-1:0] mem_addr_o;
  logic [BITSIZE-1:0] mem_wdata_o;
  logic               mem_ack_i;
  logic [BITSIZE-1:0] mem_rdata_i;
  logic               ack_i;
  logic               valid_o;
  logic [BITSIZE-1:0] instr_o;
  logic [BITSIZE-1:0] data_o;
  logic               misalign_o;
  logic               drained_o;

  modport slave (
    input  halt_i, valid_i, instr_i, result_i, rs2_i, pc_i,
           mem_ack_i, mem_rdata_i, ack_i,
    output ack_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
           valid_o, instr_o, data_o, misalign_o, drained_o
  );

  modport master (
    output halt_i, valid_i, instr_i, result_i, rs2_i, pc_i,
           mem_ack_i, mem_rdata_i, ack_i,
    input  ack_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
           valid_o, instr_o, data_o, misalign_o, drained_o
  );
endinterface

// File: rtl/mem_stage_sb_store_buffer.sv
// In-order posted-store FIFO with a parallel word-address match against all
// live entries, used to hold back loads that would bypass an older store.
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        push,
  input  sb_entry_t   push_entry,
  input  logic        pop,
  input  logic [29:0] cmp_addr,
  output sb_entry_t   head,
  output logic        full,
  output logic        empty,
  output logic        hit_o
);
  localparam int unsigned PW = $clog2(SB_DEPTH);

  sb_entry_t             entries [SB_DEPTH];
  logic [SB_DEPTH-1:0]   live;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= '0;
    end else begin
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        live[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        live[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_entry;
  end

  always_comb begin
    hit_o = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (live[i] && entries[i].addr == cmp_addr) hit_o = 1'b1;
    end
  end

  assign head  = entries[rd_ptr];
  assign full  = (count == (PW+1)'(SB_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_stage_sb.sv
// EX->WB memory stage: stores retire into a posted buffer drained in the
// background; loads use the memory port once no older store to the word waits.
module mem_stage_sb
  import mem_pkg::*;
#(
  parameter int unsigned BITSIZE  = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input logic           clk,
  input logic           rstn_i,
  mem_stage_sb_if.slave bus
);
  mem_state_t state, state_nxt;

  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [1:0]         off;
  logic               is_load, is_store, is_link, misal;
  logic               out_free, run;

  logic               ack, push, pop, out_we, out_mis, hold_we, ld_start;
  logic [BITSIZE-1:0] out_data;

  logic [BITSIZE-1:0] ld_addr;
  logic [2:0]         ld_f3;
  logic [BITSIZE-1:0] ld_data;
  logic [BITSIZE-1:0] hold_data;

  logic               valid_q, mis_q;
  logic [BITSIZE-1:0] instr_q, data_q;

  sb_entry_t          push_entry, head;
  logic               sb_full, sb_empty, sb_hit;

  assign opcode   = bus.instr_i[6:0];
  assign f3       = bus.instr_i[14:12];
  assign off      = bus.result_i[1:0];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_link  = (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_AUIPC);
  assign misal    = (is_load || is_store) &&
                    ((f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00));
  assign out_free = !valid_q || bus.ack_i;
  assign run      = !bus.halt_i;
  assign ld_data  = load_extract(bus.mem_rdata_i, ld_addr[1:0], ld_f3);

  assign push_entry.addr  = bus.result_i[31:2];
  assign push_entry.be    = store_be(f3[1:0], off);
  assign push_entry.wdata = bus.rs2_i << {off, 3'b000};

  store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .cmp_addr   (bus.result_i[31:2]),
    .head       (head),
    .full       (sb_full),
    .empty      (sb_empty),
    .hit_o      (sb_hit)
  );

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i)  state <= IDLE;
    else if (run) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.valid_i && is_load && !misal && !sb_hit) state_nxt = LOAD;
             else if (!sb_empty)                              state_nxt = DRAIN;
      LOAD:  if (bus.mem_ack_i) state_nxt = out_free ? IDLE : HOLD;
      HOLD:  if (out_free)      state_nxt = IDLE;
      DRAIN: if (bus.mem_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // EX keeps presenting a load until it is acked, so in LOAD/HOLD valid_i
  // is that same load and only non-load traffic is taken in IDLE/DRAIN.
  always_comb begin
    ack      = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    out_we   = 1'b0;
    out_mis  = 1'b0;
    out_data = '0;
    hold_we  = 1'b0;
    ld_start = 1'b0;
    case (state)
      IDLE, DRAIN: begin
        if (bus.valid_i) begin
          if (misal) begin
            if (out_free) begin
              ack     = 1'b1;
              out_we  = 1'b1;
              out_mis = 1'b1;
            end
          end else if (is_store) begin
            if (out_free && !sb_full) begin
              ack    = 1'b1;
              push   = 1'b1;
              out_we = 1'b1;
            end
          end else if (!is_load) begin
            if (out_free) begin
              ack      = 1'b1;
              out_we   = 1'b1;
              out_data = is_link ? bus.pc_i + BITSIZE'(4) : bus.result_i;
            end
          end
        end
        if (state == IDLE) ld_start = bus.valid_i && is_load && !misal && !sb_hit;
        else               pop      = bus.mem_ack_i;
      end
      LOAD: begin
        if (bus.mem_ack_i) begin
          if (out_free) begin
            ack      = 1'b1;
            out_we   = 1'b1;
            out_data = ld_data;
          end else begin
            hold_we = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          ack      = 1'b1;
          out_we   = 1'b1;
          out_data = hold_data;
        end
      end
      default: ;
    endcase
    if (!run) begin
      ack      = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      out_we   = 1'b0;
      hold_we  = 1'b0;
      ld_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      ld_addr   <= '0;
      ld_f3     <= '0;
      hold_data <= '0;
    end else if (run) begin
      if (ld_start) begin
        ld_addr <= bus.result_i;
        ld_f3   <= f3;
      end
      if (hold_we) hold_data <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      instr_q <= '0;
      data_q  <= '0;
    end else if (run) begin
      if (out_we) begin
        valid_q <= 1'b1;
        mis_q   <= out_mis;
        instr_q <= bus.instr_i;
        data_q  <= out_data;
      end else if (bus.ack_i) begin
        valid_q <= 1'b0;
        mis_q   <= 1'b0;
      end
    end
  end

  assign bus.ack_o       = ack;
  assign bus.valid_o     = valid_q;
  assign bus.misalign_o  = mis_q;
  assign bus.instr_o     = instr_q;
  assign bus.data_o      = data_q;
  assign bus.mem_req_o   = (state == LOAD) || (state == DRAIN);
  assign bus.mem_we_o    = (state == DRAIN);
  assign bus.mem_be_o    = (state == LOAD)  ? 4'hF :
                           (state == DRAIN) ? head.be : 4'h0;
  assign bus.mem_addr_o  = (state == LOAD)  ? {ld_addr[31:2], 2'b00} :
                           (state == DRAIN) ? {head.addr, 2'b00} : '0;
  assign bus.mem_wdata_o = (state == DRAIN) ? head.wdata : '0;
  assign bus.drained_o   = sb_empty && (state == IDLE);

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: stores, loads, ordering, full buffer,
// misalignment, HOLD, halt and reset while draining.
module tb_mem_stage_sb;
  import mem_pkg::*;

  logic clk;
  logic rstn;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_stage_sb_if #(.BITSIZE(32)) bus ();

  mem_stage_sb #(.BITSIZE(32), .SB_DEPTH(4)) dut (
    .clk    (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] fn);
    return {17'd0, fn, 5'd0, op};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] res, input logic [31:0] rs2);
    bus.valid_i  = 1'b1;
    bus.instr_i  = ins;
    bus.result_i = res;
    bus.rs2_i    = rs2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    rstn            = 1'b0;
    bus.halt_i      = 1'b0;
    bus.valid_i     = 1'b0;
    bus.instr_i     = '0;
    bus.result_i    = '0;
    bus.rs2_i       = '0;
    bus.pc_i        = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    bus.ack_i       = 1'b1;
    cyc();
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_drained", bus.drained_o, 1);
    chk("rst_data_o", bus.data_o, 0);
    cyc();
    rstn = 1'b1;

    // SB at 0x102
    drive(mk(OP_STORE, F3_B), 32'h102, 32'hAB);
    #1 chk("sb_ack", bus.ack_o, 1);
    cyc(); bus.valid_i = 1'b0;
    chk("sb_valid_o", bus.valid_o, 1);
    chk("sb_data_o", bus.data_o, 0);
    chk("sb_drained", bus.drained_o, 0);
    cyc();
    chk("sb_req", bus.mem_req_o, 1);
    chk("sb_we", bus.mem_we_o, 1);
    chk("sb_addr", bus.mem_addr_o, 32'h100);
    chk("sb_be", 32'(bus.mem_be_o), 32'h4);
    chk("sb_wdata", bus.mem_wdata_o, 32'h00AB0000);
    bus.mem_ack_i = 1'b1;
    cyc(); bus.mem_ack_i = 1'b0;
    chk("sb_done_req", bus.mem_req_o, 0);
    chk("sb_done_drained", bus.drained_o, 1);

    // LBU / LB at 0x103
    drive(mk(OP_LOAD, F3_BU), 32'h103, 0);
    #1 chk("lbu_no_ack", bus.ack_o, 0);
    cyc();
    chk("lbu_req", bus.mem_req_o, 1);
    chk("lbu_we", bus.mem_we_o, 0);
    chk("lbu_be", 32'(bus.mem_be_o), 32'hF);
    chk("lbu_addr", bus.mem_addr_o, 32'h100);
    bus.mem_rdata_i = 32'h80FF1234;
    bus.mem_ack_i   = 1'b1;
    #1 chk("lbu_ack", bus.ack_o, 1);
    cyc(); bus.valid_i = 1'b0; bus.mem_ack_i = 1'b0;
    chk("lbu_valid_o", bus.valid_o, 1);
    chk("lbu_data", bus.data_o, 32'h00000080);
    chk("lbu_req_off", bus.mem_req_o, 0);
    drive(mk(OP_LOAD, F3_B), 32'h103, 0);
    cyc();
    bus.mem_ack_i = 1'b1;
    #1 chk("lb_ack", bus.ack_o, 1);
    cyc(); bus.valid_i = 1'b0; bus.mem_ack_i = 1'b0;
    chk("lb_data", bus.data_o, 32'hFFFFFF80);

    // SW 0x200 then LW 0x200: drain first
    drive(mk(OP_STORE, F3_W), 32'h200, 32'h11223344);
    #1 chk("sw_ack", bus.ack_o, 1);
    cyc();
    drive(mk(OP_LOAD, F3_W), 32'h200, 0);
    #1 chk("lw_conf_wait", bus.ack_o, 0);
    cyc();
    chk("lw_conf_drain_we", bus.mem_we_o, 1);
    chk("lw_conf_drain_addr", bus.mem_addr_o, 32'h200);
    bus.mem_ack_i = 1'b1;
    #1 chk("lw_conf_no_ack", bus.ack_o, 0);
    cyc(); bus.mem_ack_i = 1'b0;
    chk("lw_conf_gap", bus.mem_req_o, 0);
    cyc();
    chk("lw_conf_req", bus.mem_req_o, 1);
    chk("lw_conf_rd", bus.mem_we_o, 0);
    bus.mem_rdata_i = 32'hCAFEF00D;
    bus.mem_ack_i   = 1'b1;
    #1 chk("lw_conf_ack", bus.ack_o, 1);
    cyc(); bus.valid_i = 1'b0; bus.mem_ack_i = 1'b0;
    chk("lw_conf_data", bus.data_o, 32'hCAFEF00D);

    // SW 0x200 then LW 0x300: load bypasses the drain
    drive(mk(OP_STORE, F3_W), 32'h200, 32'h55667788);
    cyc();
    drive(mk(OP_LOAD, F3_W), 32'h300, 0);
    cyc();
    chk("lw_byp_req", bus.mem_req_o, 1);
    chk("lw_byp_rd", bus.mem_we_o, 0);
    chk("lw_byp_addr", bus.mem_addr_o, 32'h300);
    bus.mem_rdata_i = 32'h12345678;
    bus.mem_ack_i   = 1'b1;
    cyc(); bus.valid_i = 1'b0; bus.mem_ack_i = 1'b0;
    chk("lw_byp_data", bus.data_o, 32'h12345678);
    chk("lw_byp_pending", bus.drained_o, 0);
    cyc();
    chk("lw_byp_drain_we", bus.mem_we_o, 1);
    chk("lw_byp_drain_wd", bus.mem_wdata_o, 32'h55667788);
    bus.mem_ack_i = 1'b1;
    cyc(); bus.mem_ack_i = 1'b0;
    chk("lw_byp_drained", bus.drained_o, 1);

    // five stores into a 4-deep buffer with memory stalled
    for (int i = 0; i < 4; i++) begin
      drive(mk(OP_STORE, F3_B), 32'h400 + 32'(4 * i), 32'(i));
      #1 chk("full_fill_ack", bus.ack_o, 1);
      cyc();
    end
    drive(mk(OP_STORE, F3_B), 32'h410, 32'h4);
    #1 chk("full_5th_ack", bus.ack_o, 0);
    cyc();
    chk("full_5th_wait", bus.ack_o, 0);
    chk("full_head_addr", bus.mem_addr_o, 32'h400);
    chk("full_head_be", 32'(bus.mem_be_o), 32'h1);
    bus.mem_ack_i = 1'b1;
    #1 chk("full_pop_cycle_ack", bus.ack_o, 0);
    cyc(); bus.mem_ack_i = 1'b0;
    #1 chk("full_after_pop_ack", bus.ack_o, 1);
    cyc(); bus.valid_i = 1'b0;
    bus.mem_ack_i = 1'b1;
    for (int k = 0; k < 50 && !bus.drained_o; k++) cyc();
    bus.mem_ack_i = 1'b0;
    chk("full_all_drained", bus.drained_o, 1);

    // LH at 0x101 is misaligned; then a plain ALU op
    drive(mk(OP_LOAD, F3_H), 32'h101, 0);
    #1 chk("mis_ack", bus.ack_o, 1);
    cyc();
    chk("mis_valid_o", bus.valid_o, 1);
    chk("mis_flag", bus.misalign_o, 1);
    chk("mis_data", bus.data_o, 0);
    chk("mis_no_req", bus.mem_req_o, 0);
    drive(32'h00000013, 32'h55, 0);
    cyc(); bus.valid_i = 1'b0;
    chk("alu_data", bus.data_o, 32'h55);
    chk("alu_flag", bus.misalign_o, 0);
    cyc();

    // JAL with WB stalled, then a load that must go through HOLD
    bus.ack_i = 1'b0;
    bus.pc_i  = 32'h1000;
    drive(mk(OP_JAL, 3'b000), 32'hDEAD, 0);
    #1 chk("jal_ack", bus.ack_o, 1);
    cyc();
    chk("jal_data", bus.data_o, 32'h1004);
    drive(mk(OP_LOAD, F3_W), 32'h500, 0);
    cyc();
    bus.mem_rdata_i = 32'hDEADBEEF;
    bus.mem_ack_i   = 1'b1;
    #1 chk("hold_no_ack", bus.ack_o, 0);
    cyc(); bus.mem_ack_i = 1'b0;
    chk("hold_req_off", bus.mem_req_o, 0);
    chk("hold_data_kept", bus.data_o, 32'h1004);
    chk("hold_wait_ack", bus.ack_o, 0);
    cyc();
    bus.ack_i = 1'b1;
    #1 chk("hold_release_ack", bus.ack_o, 1);
    cyc(); bus.valid_i = 1'b0;
    chk("hold_valid_o", bus.valid_o, 1);
    chk("hold_data", bus.data_o, 32'hDEADBEEF);

    // halt blocks acceptance; then reset while draining
    bus.halt_i = 1'b1;
    drive(mk(OP_STORE, F3_W), 32'h700, 32'h77);
    #1 chk("halt_no_ack", bus.ack_o, 0);
    cyc();
    chk("halt_no_push", bus.drained_o, 1);
    bus.halt_i = 1'b0;
    #1 chk("unhalt_ack", bus.ack_o, 1);
    cyc(); bus.valid_i = 1'b0;
    cyc();
    chk("rstd_req", bus.mem_req_o, 1);
    chk("rstd_addr", bus.mem_addr_o, 32'h700);
    rstn = 1'b0;
    #1;
    chk("rstd_drained", bus.drained_o, 1);
    chk("rstd_req_off", bus.mem_req_o, 0);
    chk("rstd_valid_o", bus.valid_o, 0);
    cyc();
    rstn = 1'b1;
    cyc();
    chk("rstd_stays_idle", bus.mem_req_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
